// File: rtl/pipeline_scoreboard.sv
// Register scoreboard: per-register countdown / unbounded flag, RAW/WAW stall, stall counter.
// Optional operand bypass on last-cycle results when SCOREBOARD_FWD_EN is defined.
module pipeline_scoreboard #(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LAT_W      = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [6:0]            issue_opcode,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic [LAT_W-1:0]      issue_lat,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  stall,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  fwd_rs1_hit,
  output logic                  fwd_rs2_hit,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic [LAT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] unb;

  logic uses_rs1, uses_rs2, writes_op, writes_rd;
  logic fwd_ok1, fwd_ok2;
  logic raw1, raw2, waw, hazard;
  logic fire_wr;

  // Operand usage decode
  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_op = 1'b0;
    case (issue_opcode)
      OP_R: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_op = 1'b1;
      end
      OP_I, OP_LOAD, OP_JALR: begin
        uses_rs1  = 1'b1;
        writes_op = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_JAL, OP_AUIPC, OP_LUI: writes_op = 1'b1;
      default: ;
    endcase
  end

  assign writes_rd = writes_op & (issue_rd != '0);

  always_comb begin
    busy_vec[0] = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy_vec[r] = (cnt[r] != '0) | unb[r];
    end
  end

`ifdef SCOREBOARD_FWD_EN
  // A bounded result in its final cycle is bypassed instead of stalling
  assign fwd_ok1     = (cnt[issue_rs1] == LAT_W'(1)) & ~unb[issue_rs1];
  assign fwd_ok2     = (cnt[issue_rs2] == LAT_W'(1)) & ~unb[issue_rs2];
  assign fwd_rs1_hit = issue_valid & uses_rs1 & (issue_rs1 != '0) & fwd_ok1;
  assign fwd_rs2_hit = issue_valid & uses_rs2 & (issue_rs2 != '0) & fwd_ok2;
`else
  assign fwd_ok1     = 1'b0;
  assign fwd_ok2     = 1'b0;
  assign fwd_rs1_hit = 1'b0;
  assign fwd_rs2_hit = 1'b0;
`endif

  assign raw1    = uses_rs1 & (issue_rs1 != '0) & busy_vec[issue_rs1] & ~fwd_ok1;
  assign raw2    = uses_rs2 & (issue_rs2 != '0) & busy_vec[issue_rs2] & ~fwd_ok2;
  assign waw     = writes_rd & busy_vec[issue_rd];
  assign hazard  = raw1 | raw2 | waw;

  assign stall       = issue_valid & hazard;
  assign issue_ready = ~hazard;
  assign fire_wr     = issue_valid & ~hazard & writes_rd;

  // Entry update: new issue beats same-cycle writeback, which beats countdown
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
      unb <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (fire_wr && (issue_rd == REG_ADDR_W'(r))) begin
          cnt[r] <= issue_lat;
          unb[r] <= (issue_lat == '0);
        end else if (wb_valid && (wb_rd == REG_ADDR_W'(r))) begin
          cnt[r] <= '0;
          unb[r] <= 1'b0;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - LAT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Self-checking bench for pipeline_scoreboard: directed scenarios plus random traffic
// against a release-time model of pending register writes.
module tb_pipeline_scoreboard;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

`ifdef SCOREBOARD_FWD_EN
  localparam int EXP_T2 = 1;
`else
  localparam int EXP_T2 = 2;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [6:0]  issue_opcode;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic [3:0]  issue_lat;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        stall;
  logic [31:0] busy_vec;
  logic        fwd_rs1_hit, fwd_rs2_hit;
  logic [31:0] stall_count;

  always #5 clock = ~clock;

  pipeline_scoreboard dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_opcode(issue_opcode), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_lat(issue_lat),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall(stall), .busy_vec(busy_vec),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
    .stall_count(stall_count)
  );

  int     n_chk, n_fail, n;
  bit     chk_en, last_stall;
  longint cyc, msc;
  longint free_at [32];
  bit     munb [32];
  logic [6:0] ops [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait budget expired", name);
  endtask

  function automatic bit f_u1(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_STORE, OP_LOAD, OP_BRANCH, OP_JALR};
  endfunction
  function automatic bit f_u2(input logic [6:0] op);
    return op inside {OP_R, OP_STORE, OP_BRANCH};
  endfunction
  function automatic bit f_wr(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LOAD, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI};
  endfunction

  // A register is pending until its release cycle, or indefinitely while unbounded
  function automatic bit mbusy(input int r);
    return (r != 0) && ((cyc < free_at[r]) || munb[r]);
  endfunction
  function automatic bit mfwd(input int r);
`ifdef SCOREBOARD_FWD_EN
    return (r != 0) && !munb[r] && (free_at[r] == cyc + 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_instr(input bit v, input logic [6:0] op, input int rd, input int rs1,
                           input int rs2, input int lat);
    issue_valid  = v;
    issue_opcode = op;
    issue_rd     = 5'(rd);
    issue_rs1    = 5'(rs1);
    issue_rs2    = 5'(rs2);
    issue_lat    = 4'(lat);
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance the model
  task automatic step();
    bit u1, u2, w, raw1, raw2, waw, hz, f1, f2, fire;
    logic [31:0] bv;
    @(negedge clock);
    u1   = f_u1(issue_opcode);
    u2   = f_u2(issue_opcode);
    w    = f_wr(issue_opcode) && (issue_rd != 0);
    raw1 = u1 && mbusy(int'(issue_rs1)) && !mfwd(int'(issue_rs1));
    raw2 = u2 && mbusy(int'(issue_rs2)) && !mfwd(int'(issue_rs2));
    waw  = w && mbusy(int'(issue_rd));
    hz   = raw1 || raw2 || waw;
    f1   = issue_valid && u1 && mfwd(int'(issue_rs1));
    f2   = issue_valid && u2 && mfwd(int'(issue_rs2));
    for (int r = 0; r < 32; r++) bv[r] = mbusy(r);
    if (chk_en) begin
      chk("stall", 64'(stall), 64'(issue_valid && hz));
      chk("issue_ready", 64'(issue_ready), 64'(!hz));
      chk("busy_vec", 64'(busy_vec), 64'(bv));
      chk("fwd_rs1_hit", 64'(fwd_rs1_hit), 64'(f1));
      chk("fwd_rs2_hit", 64'(fwd_rs2_hit), 64'(f2));
      chk("stall_count", 64'(stall_count), 64'(msc));
    end
    last_stall = issue_valid && hz;
    fire       = issue_valid && !hz;
    @(posedge clock);
    if (!reset) begin
      for (int r = 0; r < 32; r++) begin
        free_at[r] = 0;
        munb[r]    = 1'b0;
      end
      msc = 0;
    end else begin
      if (wb_valid && wb_rd != 0) begin
        free_at[wb_rd] = cyc + 1;
        munb[wb_rd]    = 1'b0;
      end
      if (fire && w) begin
        if (issue_lat != 0) begin
          free_at[issue_rd] = cyc + 1 + longint'(issue_lat);
          munb[issue_rd]    = 1'b0;
        end else begin
          munb[issue_rd] = 1'b1;
        end
      end
      if (last_stall && msc != 64'hFFFF_FFFF) msc++;
    end
    cyc++;
    #1;
  endtask

  initial begin
    ops[0] = OP_R;   ops[1] = OP_I;     ops[2] = OP_LOAD; ops[3] = OP_STORE;
    ops[4] = OP_BRANCH; ops[5] = OP_JALR; ops[6] = OP_JAL; ops[7] = OP_AUIPC;
    ops[8] = OP_LUI; ops[9] = OP_SYS;
    n_chk = 0; n_fail = 0; chk_en = 1'b0; cyc = 0; msc = 0;
    for (int r = 0; r < 32; r++) begin free_at[r] = 0; munb[r] = 1'b0; end
    reset = 1'b0; wb_valid = 1'b0; wb_rd = '0;
    set_instr(0, 7'h00, 0, 0, 0, 0);

    // Reset held two cycles
    step(); step();
    chk_en = 1'b1;
    reset  = 1'b1;
    chk("rst_busy_vec", 64'(busy_vec), 64'h0);
    chk("rst_stall_count", 64'(stall_count), 64'h0);
    chk("rst_issue_ready", 64'(issue_ready), 64'h1);

    // RAW on a bounded result
    set_instr(1, OP_R, 1, 0, 0, 2); step();
    set_instr(1, OP_R, 4, 1, 3, 1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!last_stall) break;
      n++;
    end
    if (last_stall) timeout_fail("t2_wait");
    chk("t2_stalls", 64'(n), 64'(EXP_T2));
    chk("t2_stall_count", 64'(stall_count), 64'(EXP_T2));

    // RAW on an unbounded load released by writeback
    set_instr(1, OP_LOAD, 10, 0, 0, 0); step();
    set_instr(1, OP_BRANCH, 0, 2, 10, 0);
    step(); step(); step();
    chk("t3_waiting", 64'(last_stall), 64'h1);
    wb_valid = 1'b1; wb_rd = 5'd10;
    step();
    chk("t3_wb_cycle", 64'(last_stall), 64'h1);
    wb_valid = 1'b0;
    step();
    chk("t3_fire", 64'(last_stall), 64'h0);
    chk("t3_busy10", 64'(busy_vec[10]), 64'h0);

    // WAW stall
    set_instr(1, OP_I, 5, 0, 0, 3); step();
    set_instr(1, OP_LUI, 5, 0, 0, 1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!last_stall) break;
      n++;
    end
    if (last_stall) timeout_fail("t4_wait");
    chk("t4_waw_stalls", 64'(n), 64'd3);

    // x0 never tracked
    set_instr(1, OP_I, 0, 0, 0, 4); step();
    chk("t5_busy0", 64'(busy_vec[0]), 64'h0);
    set_instr(1, OP_R, 0, 0, 0, 1); step();
    chk("t5_no_stall", 64'(last_stall), 64'h0);

    // Issue beats same-cycle writeback; reset clears pending entries
    set_instr(1, OP_I, 7, 0, 0, 0);
    wb_valid = 1'b1; wb_rd = 5'd7;
    step();
    wb_valid = 1'b0;
    chk("t6_busy7", 64'(busy_vec[7]), 64'h1);
    set_instr(1, OP_R, 0, 7, 0, 1);
    step(); step();
    chk("t6_stalling", 64'(last_stall), 64'h1);
    reset = 1'b0; step(); reset = 1'b1;
    chk("t6_rst_busy", 64'(busy_vec), 64'h0);
    chk("t6_rst_count", 64'(stall_count), 64'h0);
    step();
    chk("t6_after_rst", 64'(last_stall), 64'h0);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      set_instr($urandom_range(0, 3) != 0, ops[$urandom_range(0, 9)],
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)),
                ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 6)));
      wb_valid = ($urandom_range(0, 3) == 0);
      wb_rd    = 5'($urandom_range(0, 7));
      reset    = ($urandom_range(0, 199) != 0);
      step();
    end
    reset = 1'b1; wb_valid = 1'b0;
    set_instr(0, 7'h00, 0, 0, 0, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
